// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer: layer-type and
// FSM state enums, descriptor field offsets, watchdog counter width and
// small helpers that decode a descriptor header.
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        LT_CONV = 2'd0,
        LT_POOL = 2'd1,
        LT_FC   = 2'd2,
        LT_RSVD = 2'd3
    } layer_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR   = 3'd4
    } seq_state_e;

    // Descriptor layout: [1:0] type, [2] last flag, [DESC_WIDTH-1:3] opaque config
    localparam int TYPE_LSB = 0;
    localparam int LAST_BIT = 2;
    localparam int CFG_LSB  = 3;

    // Watchdog counter width
    localparam int WDOG_W = 16;

    // Layer type from the descriptor header bits
    function automatic layer_type_e desc_type(input logic [CFG_LSB-1:0] hdr);
        return layer_type_e'(hdr[TYPE_LSB +: 2]);
    endfunction

    // Explicit last-layer flag from the descriptor header bits
    function automatic logic desc_last(input logic [CFG_LSB-1:0] hdr);
        return hdr[LAST_BIT];
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Bundle of the sequencer's host programming/control signals and the engine
// launch/completion handshakes. The slave modport is the sequencer side; the
// master modport is the host/engine side.
interface cnn_layer_sequencer_if #(
    parameter int MAX_LAYERS = 8,
    parameter int DESC_WIDTH = 64
);
    localparam int AW = $clog2(MAX_LAYERS);

    // Host programming and control
    logic                  prog_we;
    logic [AW-1:0]         prog_addr;
    logic [DESC_WIDTH-1:0] prog_data;
    logic                  start;
    logic                  abort;

    // Engine handshakes
    logic                  conv_valid_in;
    logic                  conv_valid_out;
    logic                  pool_valid_in;
    logic                  pool_valid_out;
    logic                  fc_en;
    logic                  fc_valid;

    // Status
    logic [AW-1:0]         cur_layer;
    logic [DESC_WIDTH-1:0] cur_desc;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [AW-1:0]         err_layer;

    modport slave (
        input  prog_we, prog_addr, prog_data, start, abort,
        input  conv_valid_out, pool_valid_out, fc_valid,
        output conv_valid_in, pool_valid_in, fc_en,
        output cur_layer, cur_desc, busy, done, error, err_layer
    );

    modport master (
        output prog_we, prog_addr, prog_data, start, abort,
        output conv_valid_out, pool_valid_out, fc_valid,
        input  conv_valid_in, pool_valid_in, fc_en,
        input  cur_layer, cur_desc, busy, done, error, err_layer
    );

endinterface

// File: rtl/cnn_seq_desc_mem.sv
// Descriptor register file: MAX_LAYERS slots of DESC_WIDTH bits, synchronous
// write, combinational read, every slot cleared by the synchronous
// active-low reset so an unprogrammed slot reads as a non-last conv layer.
module cnn_seq_desc_mem #(
    parameter int MAX_LAYERS = 8,
    parameter int DESC_WIDTH = 64,
    localparam int AW = $clog2(MAX_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DESC_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DESC_WIDTH-1:0] rdata_o
);

    logic [DESC_WIDTH-1:0] slot_view [MAX_LAYERS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAYERS; gi++) begin : g_slot
            logic [DESC_WIDTH-1:0] slot_q;

            // One slot: cleared on reset, loaded when its address is written
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (we_i && (waddr_i == AW'(gi))) begin
                    slot_q <= wdata_i;
                end
            end

            assign slot_view[gi] = slot_q;
        end
    endgenerate

    assign rdata_o = slot_view[raddr_i];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: walks a descriptor program from slot 0, launching the
// conv/pool/fc engine selected by each descriptor and waiting for that
// engine's completion before moving on. A reserved descriptor type stops the
// run in ERR.
// Optional feature macro: CNN_SEQ_TIMEOUT_EN builds a WAIT-state watchdog that
// faults a layer whose engine does not complete within TIMEOUT_CYCLES cycles.
// The TIMEOUT_CYCLES parameter only exists when that macro is defined.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int DESC_WIDTH = 64
`ifdef CNN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_layer_sequencer_if.slave  bus
);

    localparam int AW = $clog2(MAX_LAYERS);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         cur_layer_q, cur_layer_d;
    logic [DESC_WIDTH-1:0] cur_desc_q, cur_desc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [AW-1:0]         err_layer_q, err_layer_d;
`ifdef CNN_SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
`endif

    logic [DESC_WIDTH-1:0] mem_rdata;
    layer_type_e           cur_type;
    layer_type_e           fetch_type;
    logic                  completion;
    logic                  is_last;

    // Writes are accepted only between runs; a write in the start cycle is
    // committed at that edge, before slot 0 is read in FETCH.
    cnn_seq_desc_mem #(
        .MAX_LAYERS (MAX_LAYERS),
        .DESC_WIDTH (DESC_WIDTH)
    ) u_desc_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (bus.prog_we && !busy_q),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (cur_layer_q),
        .rdata_o (mem_rdata)
    );

    assign cur_type   = desc_type(cur_desc_q[CFG_LSB-1:0]);
    assign fetch_type = desc_type(mem_rdata[CFG_LSB-1:0]);
    assign is_last    = desc_last(cur_desc_q[CFG_LSB-1:0]) ||
                        (cur_layer_q == AW'(MAX_LAYERS - 1));

    // Only the completion of the engine that was launched is looked at
    always_comb begin
        completion = 1'b0;
        case (cur_type)
            LT_CONV: completion = bus.conv_valid_out;
            LT_POOL: completion = bus.pool_valid_out;
            LT_FC:   completion = bus.fc_valid;
            default: completion = 1'b0;
        endcase
    end

    // Next-state logic; abort overrides every other event in the same cycle
    always_comb begin
        state_d     = state_q;
        cur_layer_d = cur_layer_q;
        cur_desc_d  = cur_desc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_layer_d = err_layer_q;
`ifdef CNN_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif
        if (bus.abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        state_d     = S_FETCH;
                        cur_layer_d = '0;
                        busy_d      = 1'b1;
                        error_d     = 1'b0;
                    end
                end
                S_FETCH: begin
                    cur_desc_d = mem_rdata;
                    if (fetch_type == LT_RSVD) begin
                        state_d     = S_ERR;
                        err_layer_d = cur_layer_q;
                        busy_d      = 1'b0;
                        error_d     = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef CNN_SEQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (completion) begin
                        if (is_last) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d     = S_FETCH;
                            cur_layer_d = cur_layer_q + AW'(1);
                        end
                    end
`ifdef CNN_SEQ_TIMEOUT_EN
                    // wdog_q holds the number of WAIT cycles already spent
                    else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = S_ERR;
                        err_layer_d = cur_layer_q;
                        busy_d      = 1'b0;
                        error_d     = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_layer_q <= '0;
            cur_desc_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_layer_q <= '0;
`ifdef CNN_SEQ_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_layer_q <= cur_layer_d;
            cur_desc_q  <= cur_desc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_layer_q <= err_layer_d;
`ifdef CNN_SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    // Launch pulses depend only on registered state and descriptor
    assign bus.conv_valid_in = (state_q == S_ISSUE) && (cur_type == LT_CONV);
    assign bus.pool_valid_in = (state_q == S_ISSUE) && (cur_type == LT_POOL);
    assign bus.fc_en         = (state_q == S_ISSUE) && (cur_type == LT_FC);

    assign bus.cur_layer = cur_layer_q;
    assign bus.cur_desc  = cur_desc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_layer = err_layer_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: a vector table for the basic
// conv/pool/fc run, then hand sequences for the reserved-type fault, the
// eight-slot implicit-last run, abort with completion, programming rules and
// (with CNN_SEQ_TIMEOUT_EN) the watchdog.
module tb_cnn_layer_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer_if #(.MAX_LAYERS(8), .DESC_WIDTH(64)) bus ();

    cnn_layer_sequencer #(
        .MAX_LAYERS (8),
        .DESC_WIDTH (64)
`ifdef CNN_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       start;
        logic       abort;
        logic       cvo;
        logic       pvo;
        logic       fv;
        logic [2:0] launch;   // {conv, pool, fc}
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] layer;
    } vec_t;

    vec_t vecs [13];

    // Packed view {conv_launch, pool_launch, fc_launch, busy, done, error, cur_layer}
    function automatic logic [8:0] snap();
        return {bus.conv_valid_in, bus.pool_valid_in, bus.fc_en,
                bus.busy, bus.done, bus.error, bus.cur_layer};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [2:0] addr, input logic [63:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.prog_we        = 1'b0;
        bus.prog_addr      = '0;
        bus.prog_data      = '0;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.conv_valid_out = 1'b0;
        bus.pool_valid_out = 1'b0;
        bus.fc_valid       = 1'b0;

        //                name            st ab cv pv fv launch  bs dn er layer
        vecs[0]  = '{"s1_start_fetch",    1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'd0};
        vecs[1]  = '{"s1_conv_launch",    0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 3'd0};
        vecs[2]  = '{"s1_wait0",          0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'd0};
        vecs[3]  = '{"s1_wait0b",         0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'd0};
        vecs[4]  = '{"s1_stray_pool",     0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 3'd0};
        vecs[5]  = '{"s1_conv_done",      0, 0, 1, 0, 0, 3'b000, 1, 0, 0, 3'd1};
        vecs[6]  = '{"s1_pool_launch",    0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 3'd1};
        vecs[7]  = '{"s1_wait1",          0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'd1};
        vecs[8]  = '{"s1_pool_done",      0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 3'd2};
        vecs[9]  = '{"s1_fc_launch",      0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 3'd2};
        vecs[10] = '{"s1_fc_in_issue",    0, 0, 1, 0, 1, 3'b000, 1, 0, 0, 3'd2};
        vecs[11] = '{"s1_fc_done",        0, 0, 0, 0, 1, 3'b000, 0, 1, 0, 3'd2};
        vecs[12] = '{"s1_idle_after",     0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'd2};

        // Reset state
        tick();
        tick();
        check("reset_outputs", 64'(snap()), 64'h0);
        check("reset_cur_desc", bus.cur_desc, 64'h0);
        check("reset_err_layer", 64'(bus.err_layer), 64'h0);
        rst_n = 1'b1;

        // Cleared memory: slot 0 runs as a non-last conv
        pulse_start();
        tick();
        check("cleared_slot0_conv", 64'(snap()), 64'(9'b100_1_0_0_000));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("cleared_abort", 64'(snap()), 64'h0);

        // Scenario 1: conv, pool, fc(last), table driven
        prog(3'd0, 64'h1230);
        prog(3'd1, 64'h1241);
        prog(3'd2, 64'h1256);
        for (int i = 0; i < 13; i++) begin
            bus.start          = vecs[i].start;
            bus.abort          = vecs[i].abort;
            bus.conv_valid_out = vecs[i].cvo;
            bus.pool_valid_out = vecs[i].pvo;
            bus.fc_valid       = vecs[i].fv;
            tick();
            check(vecs[i].name, 64'(snap()),
                  64'({vecs[i].launch, vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].layer}));
            if (i == 9) check("s1_fc_cur_desc", bus.cur_desc, 64'h1256);
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.conv_valid_out = 1'b0; bus.pool_valid_out = 1'b0; bus.fc_valid = 1'b0;

        // Scenario 2: reserved type in slot 1
        prog(3'd0, 64'h08);
        prog(3'd1, 64'h0B);
        pulse_start();
        tick();
        check("s2_conv_launch", 64'(snap()), 64'(9'b100_1_0_0_000));
        tick();
        bus.conv_valid_out = 1'b1;
        tick();
        bus.conv_valid_out = 1'b0;
        tick();
        check("s2_err_state", 64'(snap()), 64'(9'b000_0_0_1_001));
        check("s2_err_layer", 64'(bus.err_layer), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_err_hold", 64'(snap()), 64'(9'b000_0_0_1_001));
        end
        pulse_start();
        check("s2_restart", 64'(snap()), 64'(9'b000_1_0_0_000));
        tick();
        check("s2_restart_launch", 64'(snap()), 64'(9'b100_1_0_0_000));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // Scenario 3: eight non-last conv slots, implicit last, no wrap
        for (int k = 0; k < 8; k++) prog(3'(k), 64'(k * 8));
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("s3_launch_%0d", k), 64'(snap()), 64'({3'b100, 1'b1, 1'b0, 1'b0, 3'(k)}));
            tick();
            bus.conv_valid_out = 1'b1;
            tick();
            bus.conv_valid_out = 1'b0;
        end
        check("s3_done", 64'(snap()), 64'(9'b000_0_1_0_111));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_no_wrap", 64'(snap()), 64'(9'b000_0_0_0_111));
        end

        // Scenario 4: abort together with completion, then normal restart
        prog(3'd0, 64'h10);
        prog(3'd1, 64'h0D);
        pulse_start();
        tick();
        check("s4_conv_launch", 64'(snap()), 64'(9'b100_1_0_0_000));
        tick();
        bus.abort = 1'b1;
        bus.conv_valid_out = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.conv_valid_out = 1'b0;
        check("s4_abort_idle", 64'(snap()), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s4_abort_quiet", 64'(snap()), 64'h0);
        end
        pulse_start();
        tick();
        check("s4_rerun_conv", 64'(snap()), 64'(9'b100_1_0_0_000));
        tick();
        bus.conv_valid_out = 1'b1;
        tick();
        bus.conv_valid_out = 1'b0;
        tick();
        check("s4_rerun_pool", 64'(snap()), 64'(9'b010_1_0_0_001));
        tick();
        bus.pool_valid_out = 1'b1;
        tick();
        bus.pool_valid_out = 1'b0;
        check("s4_rerun_done", 64'(snap()), 64'(9'b000_0_1_0_001));

        // Write in the start cycle lands before fetch; writes while busy drop
        bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 64'h1E;
        bus.start = 1'b1;
        tick();
        bus.prog_we = 1'b0; bus.start = 1'b0;
        tick();
        check("s5_start_write_fc", 64'(snap()), 64'(9'b001_1_0_0_000));
        tick();
        bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 64'h10;
        bus.fc_valid = 1'b1;
        tick();
        bus.prog_we = 1'b0; bus.fc_valid = 1'b0;
        check("s5_fc_done", 64'(snap()), 64'(9'b000_0_1_0_000));
        pulse_start();
        tick();
        check("s5_busy_write_dropped", 64'(snap()), 64'(9'b001_1_0_0_000));
        tick();
        bus.fc_valid = 1'b1;
        tick();
        bus.fc_valid = 1'b0;
        check("s5_second_done", 64'(snap()), 64'(9'b000_0_1_0_000));

`ifdef CNN_SEQ_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without completion faults the layer
        prog(3'd0, 64'h10);
        pulse_start();
        tick();
        check("wd_conv_launch", 64'(snap()), 64'(9'b100_1_0_0_000));
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) begin
                bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 64'h11;
            end
            tick();
            bus.prog_we = 1'b0;
        end
        check("wd_still_waiting", 64'(snap()), 64'(9'b000_1_0_0_000));
        tick();
        check("wd_timeout_err", 64'(snap()), 64'(9'b000_0_0_1_000));
        check("wd_err_layer", 64'(bus.err_layer), 64'd0);
        pulse_start();
        check("wd_restart_clears", 64'(snap()), 64'(9'b000_1_0_0_000));
        tick();
        check("wd_write_dropped", 64'(snap()), 64'(9'b100_1_0_0_000));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Programmable layer scheduler that sequences the convolution, pooling and fully-connected engines of the CNN top level through their valid handshakes. It holds a small descriptor program, launches one engine per descriptor, waits for that engine's completion, then advances. The `cur_desc` output feeds external configuration muxes. A watchdog flags engines that never complete.

## Interface
- `MAX_LAYERS`, 8: descriptor slots; power of two.
- `DESC_WIDTH`, 64: descriptor width. Bits [1:0] are the type (0 conv, 1 pool, 2 fc, 3 reserved). Bit [2] is the last flag. The rest is opaque engine configuration.
- `TIMEOUT_CYCLES`, 65535: watchdog limit; 16-bit counter.
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `prog_we` in 1: descriptor write strobe.
- `prog_addr` in $clog2(MAX_LAYERS): descriptor slot.
- `prog_data` in DESC_WIDTH: descriptor value.
- `start` in 1: run program from slot 0.
- `abort` in 1: terminate run.
- `conv_valid_in` out 1: conv launch pulse.
- `conv_valid_out` in 1: conv completion.
- `pool_valid_in` out 1: pool launch pulse.
- `pool_valid_out` in 1: pool completion.
- `fc_en` out 1: FC launch pulse.
- `fc_valid` in 1: FC completion.
- `cur_layer` out $clog2(MAX_LAYERS): active slot index.
- `cur_desc` out DESC_WIDTH: registered active descriptor.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at program completion.
- `error` out 1: sticky fault flag.
- `err_layer` out $clog2(MAX_LAYERS): slot that faulted.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, ERR.
- **IDLE:** on `start`, go to FETCH with `cur_layer`=0, `busy`=1 and `error` cleared.
- **FETCH:** `cur_desc` <= mem[`cur_layer`].
  - Type 3 goes to ERR with `err_layer`=`cur_layer`.
  - Any other type goes to ISSUE.
- **ISSUE:** the launch output selected by type is high for exactly this one cycle. The watchdog counter is cleared. Next state is WAIT.
- **WAIT:** only the completion input matching the active type is sampled; other completions are ignored.
  - On completion with the last flag set, or with `cur_layer`==MAX_LAYERS-1 (implicit last, no wrap): go to IDLE, `done`=1 for one cycle, `busy`=0.
  - Otherwise `cur_layer` increments and the state goes to FETCH.
- **ERR:** `busy`=0 and `error`=1.
  - `start` restarts the run (clears `error`).
  - `abort` goes to IDLE and clears `error`.
- **Programming:**
  - `prog_we` is honoured only while `busy`=0; writes while busy are dropped.
  - A write in the same cycle as `start` lands before the fetch of slot 0.
- **Start handling:** `start` while `busy`=1 is ignored.
- **Abort:** from any state, goes to IDLE next edge. `busy`=0, no `done`, no launch pulse, `error` cleared. `abort` has priority over `start` and over a completion in the same cycle.
- **Reset values:** all outputs 0, state IDLE, `cur_desc`=0. Descriptor memory is also cleared, so an unprogrammed slot 0 is a conv, non-last.

## Timing
- `start` sampled at edge 0 gives FETCH in cycle 1, the launch pulse visible in cycle 2, and WAIT from cycle 3.
- Completion sampled at edge t:
  - next FETCH at t+1, next launch at t+2 (two-cycle inter-layer gap);
  - for the last layer, `done` is high in cycle t+1.
- A completion asserted during ISSUE is not sampled; engines register their outputs, so the earliest legal completion is in WAIT.
- Launch outputs are decoded from the registered state and `cur_desc` only; no input-to-output combinational path.
- Reset mid-run: next edge returns everything to reset values and clears the memory.

## Configuration
- `CNN_SEQ_TIMEOUT_EN` defined:
  - the watchdog counts WAIT cycles;
  - reaching TIMEOUT_CYCLES goes to ERR with `err_layer`=`cur_layer`.
- Undefined: no counter is built, WAIT holds indefinitely, and `error` is set only by type 3.

## Structure
- Package `cnn_seq_pkg` holds:
  - the layer-type enum;
  - the state enum;
  - descriptor field offsets (TYPE_LSB=0, LAST_BIT=2, CFG_LSB=3);
  - the timeout counter width.
- Sub-module `cnn_seq_desc_mem`: MAX_LAYERS x DESC_WIDTH register file, synchronous write, combinational read, synchronous clear on reset.

## Test plan
- Program conv, pool, fc(last); start. Expect launch pulses in order at cycles 2, t1+2, t2+2. `done` pulses once one cycle after `fc_valid`. `cur_layer` steps 0,1,2.
- Slot 1 type 3; start after conv completes. Expect `error`=1, `err_layer`=1, no pool/FC launch, `busy`=0.
- No last flag in any of 8 slots. Expect 8 launches, `done` after slot 7 completion, no wrap to slot 0.
- Stray `pool_valid_out` while waiting on conv. Expect it ignored and the state to stay WAIT.
- `abort` in the same cycle as `conv_valid_out`. Expect IDLE, no `done`, no further launch. A subsequent `start` runs normally.
- With `CNN_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=16, withhold completion. Expect `error`=1 after 16 WAIT cycles. `prog_we` is dropped while busy, and `start` clears `error`.
